// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encodings, bit-period constants and small helpers.
// Used by both uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_PRE   = 6'b000010,
        S_START = 6'b000100,
        S_DATA  = 6'b001000,
        S_STOP  = 6'b010000,
        S_ERR   = 6'b100000
    } state_e;

    localparam logic [15:0] DEFAULT_T_1_BIT = 16'd5207;
    localparam logic [15:0] SIM_T_1_BIT     = 16'd9;

    function automatic logic [15:0] mid_of(input logic [15:0] t_1_bit);
        return t_1_bit >> 1;
    endfunction

    // Last cycle index of the two-bit-period start window: 2*(t+1)-1 == 2t+1.
    function automatic logic [16:0] start_timeout_of(input logic [15:0] t_1_bit);
        return {t_1_bit, 1'b1};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RX pin plus a one-cycle history register,
// giving the synced level and single-cycle rise/fall strobes.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_s,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver for the idle-low / preamble / start / 8 data / stop / guard framing.
// Emits one byte per valid frame and a pulse for aborted frames.
module uart_rx
    import uart_pkg::*;
#(
    parameter logic [15:0] T_1_BIT = DEFAULT_T_1_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam logic [15:0] MID      = mid_of(T_1_BIT);
    localparam logic [16:0] TMO_LAST = start_timeout_of(T_1_BIT);

    logic rx_s;
    logic rise;
    logic fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_i  (rx_i),
        .rx_s  (rx_s),
        .rise  (rise),
        .fall  (fall)
    );

    state_e      state_q,   state_d;
    logic [15:0] cnt_q,     cnt_d;
    logic [16:0] tmo_q,     tmo_d;
    logic        armed_q,   armed_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q,   shift_d;
    logic [7:0]  data_q,    data_d;
    logic        valid_q,   valid_d;
    logic        err_q,     err_d;
    logic        busy_q,    busy_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == T_1_BIT) ? 16'd0 : cnt_q + 16'd1;
        tmo_d     = tmo_q;
        armed_d   = armed_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (cnt_q == MID) begin
                    state_d = rx_s ? S_START : S_IDLE;
                end
            end
            S_START: begin
                // The start edge re-centres the counter so every later sample lands mid-bit.
                if (fall) begin
                    cnt_d   = 16'd0;
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    if (cnt_q == MID) begin
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 17'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == T_1_BIT) begin
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == T_1_BIT) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d     = 16'd0;
            tmo_d     = 17'd0;
            armed_d   = 1'b0;
            bit_idx_d = 3'd0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            tmo_q     <= 17'd0;
            armed_q   <= 1'b0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            armed_q   <= armed_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit on rx_i and the
// output pulses are tallied by a monitor on the falling clock edge.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT = int'(SIM_T_1_BIT) + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;

    uart_rx #(.T_1_BIT(SIM_T_1_BIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         valid_cnt = 0;
    int         err_cnt = 0;
    int         overlap_cnt = 0;
    int         err_cyc = 0;
    logic [7:0] got[$];

    always @(negedge clk) begin
        if (valid_o) begin
            valid_cnt++;
            got.push_back(data_o);
            $display("rx byte %02h at cycle %0d", data_o, cyc);
        end
        if (frame_err_o) begin
            err_cnt++;
            err_cyc = cyc;
            $display("frame error pulse at cycle %0d", cyc);
        end
        if (valid_o && frame_err_o) overlap_cnt++;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input int n);
        rx_i = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic guard);
        drive(1'b1, BIT);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(d[i], BIT);
        drive(stop, BIT);
        if (guard) drive(1'b1, BIT);
        rx_i = 1'b0;
    endtask

    int start_cyc;
    int d_err;
    int w;
    int v_snap;
    int e_snap;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data_o), 32'h00);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_err", 32'(frame_err_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 5);

        // Single good frame
        send_frame(8'hA5, 1'b1, 1'b1);
        drive(1'b0, 20);
        check("a5_valid_cnt", 32'(valid_cnt), 32'd1);
        check("a5_data", 32'(data_o), 32'hA5);
        check("a5_err_cnt", 32'(err_cnt), 32'd0);
        check("a5_busy", 32'(busy_o), 32'h0);

        // Back-to-back frames separated by a single idle-low cycle
        send_frame(8'h00, 1'b1, 1'b1);
        drive(1'b0, 1);
        send_frame(8'hFF, 1'b1, 1'b1);
        drive(1'b0, 1);
        send_frame(8'h3C, 1'b1, 1'b1);
        drive(1'b0, 20);
        check("b2b_valid_cnt", 32'(valid_cnt), 32'd4);
        check("b2b_byte0", 32'(got[1]), 32'h00);
        check("b2b_byte1", 32'(got[2]), 32'hFF);
        check("b2b_byte2", 32'(got[3]), 32'h3C);
        check("b2b_err_cnt", 32'(err_cnt), 32'd0);

        // Stop bit low; guard omitted so the line stays low afterwards
        send_frame(8'h5A, 1'b0, 1'b0);
        drive(1'b0, 30);
        check("badstop_err_cnt", 32'(err_cnt), 32'd1);
        check("badstop_valid_cnt", 32'(valid_cnt), 32'd4);
        check("badstop_data_held", 32'(data_o), 32'h3C);
        check("badstop_busy", 32'(busy_o), 32'h0);

        // Short high glitch on the idle line
        drive(1'b1, 3);
        rx_i = 1'b0;
        check("glitch_busy_seen", 32'(busy_o), 32'h1);
        w = 0;
        while (busy_o && w < 12) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("glitch_busy_clear", 32'(busy_o), 32'h0);
        drive(1'b0, 10);
        check("glitch_valid_cnt", 32'(valid_cnt), 32'd4);
        check("glitch_err_cnt", 32'(err_cnt), 32'd1);

        // Preamble followed by a line stuck high: start-bit timeout
        start_cyc = cyc;
        drive(1'b1, 40);
        drive(1'b0, 10);
        d_err = err_cyc - start_cyc;
        check("stuck_err_cnt", 32'(err_cnt), 32'd2);
        check("stuck_err_timing", 32'(d_err >= 20 && d_err <= 32), 32'd1);
        check("stuck_valid_cnt", 32'(valid_cnt), 32'd4);
        check("stuck_busy", 32'(busy_o), 32'h0);

        // Reset asserted during data bit 4, held until the frame has finished
        fork
            send_frame(8'hC3, 1'b1, 1'b1);
            begin
                repeat (6 * BIT + 5) @(posedge clk);
                #1;
                rst_n = 1'b0;
            end
        join
        check("midrst_data", 32'(data_o), 32'h00);
        check("midrst_busy", 32'(busy_o), 32'h0);
        v_snap = valid_cnt;
        e_snap = err_cnt;
        rst_n = 1'b1;
        drive(1'b0, 30);
        check("midrst_no_valid", 32'(valid_cnt), 32'(v_snap));
        check("midrst_no_err", 32'(err_cnt), 32'(e_snap));

        send_frame(8'h81, 1'b1, 1'b1);
        drive(1'b0, 20);
        check("post_rst_valid_cnt", 32'(valid_cnt), 32'(v_snap + 1));
        check("post_rst_data", 32'(data_o), 32'h81);
        check("post_rst_err_cnt", 32'(err_cnt), 32'(e_snap));
        check("no_overlap", 32'(overlap_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
